layer_mac_scheduler: RTL and testbench

//  Time-multiplexes one 8-bit signed MAC across all nodes of a dense layer.

---
 rtl/layer_mac_scheduler.sv | 129 ++++++++++++
 tb/tb_layer_mac_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/layer_mac_scheduler.sv
// layer_mac_scheduler: one 8-bit MAC sequenced over all nodes of a dense layer, ReLU output; define SCHED_SAT_EN for saturating accumulate
module layer_mac_scheduler #(
  parameter int NUM_INPUTS = 30,
  parameter int NUM_NODES  = 8,
  parameter int WA_W       = 9,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*NUM_INPUTS-1:0] act_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd,
  output logic [WA_W-1:0]         w_addr,
  input  logic [7:0]              w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [7:0]              out_data
);
  localparam int KW = $clog2(NUM_INPUTS + 2);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] acts [NUM_INPUTS];
  logic [KW-1:0] k, k_n, w_k, w_k_n, p_k;
  logic [IDX_W-1:0] node, node_n, out_idx_n;
  logic [7:0] acc, acc_n, prod, addend, sum, out_data_n;
  logic p_v, busy_n, done_n, w_rd_n, out_valid_n;
  logic [WA_W-1:0] w_addr_n;
  // low 8 bits of the product are the same for signed and unsigned operands
  assign prod   = acts[p_k] * w_data;
  assign addend = (p_k == KW'(NUM_INPUTS)) ? w_data : prod;
`ifdef SCHED_SAT_EN
  logic [8:0] sum9;
  assign sum9 = {acc[7], acc} + {addend[7], addend};
  assign sum  = (sum9[8] ^ sum9[7]) ? (sum9[8] ? 8'h80 : 8'h7f) : sum9[7:0];
`else
  assign sum = acc + addend;
`endif
  always_comb begin
    state_n     = state;
    k_n         = k;
    w_k_n       = w_k;
    node_n      = node;
    acc_n       = p_v ? sum : acc;
    busy_n      = busy;
    done_n      = 1'b0;
    w_rd_n      = 1'b0;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_data_n  = out_data;
    case (state)
      IDLE: if (start) begin
        node_n  = '0;
        k_n     = '0;
        acc_n   = '0;
        busy_n  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        w_rd_n  = 1'b1;
        w_k_n   = k;
        k_n     = k + 1'b1;
        state_n = (k == KW'(NUM_INPUTS)) ? DRAIN : RUN;
      end
      DRAIN: if (p_v && p_k == KW'(NUM_INPUTS)) begin
        out_valid_n = 1'b1;
        out_idx_n   = node;
        out_data_n  = acc_n[7] ? 8'd0 : acc_n;
        state_n     = WRITE;
      end
      WRITE: if (out_ready) begin
        out_valid_n = 1'b0;
        if (node == IDX_W'(NUM_NODES - 1)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end else begin
          // the handshake edge already issues the next node's first read
          node_n  = node + 1'b1;
          acc_n   = '0;
          w_rd_n  = 1'b1;
          w_k_n   = '0;
          k_n     = KW'(1);
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
    w_addr_n = w_rd_n ? WA_W'(node_n) * WA_W'(NUM_INPUTS + 1) + WA_W'(w_k_n) : w_addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      w_k       <= '0;
      p_k       <= '0;
      p_v       <= 1'b0;
      node      <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      w_k       <= w_k_n;
      p_k       <= w_k;
      p_v       <= w_rd;
      node      <= node_n;
      acc       <= acc_n;
      busy      <= busy_n;
      done      <= done_n;
      w_rd      <= w_rd_n;
      w_addr    <= w_addr_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_data  <= out_data_n;
    end
  end
  always_ff @(posedge clk)
    if (state == IDLE && start)
      for (int i = 0; i < NUM_INPUTS; i++) acts[i] <= act_vec[8*i +: 8];
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// tb_layer_mac_scheduler: directed scenarios with an expected-result queue drained by an output monitor
module tb_layer_mac_scheduler;
  localparam int NI = 30;
  localparam int NN = 8;
  localparam int ROMSZ = NN * (NI + 1);
  logic clk = 0, reset = 1, start = 1, out_ready = 1;
  logic [8*NI-1:0] act_vec = '0;
  logic busy, done, w_rd, out_valid;
  logic [8:0] w_addr;
  logic [7:0] w_data = '0, out_data;
  logic [2:0] out_idx;
  logic [7:0] rom [ROMSZ];
  logic [10:0] exp_q [$];
  int errors = 0, checks = 0, cnt = 0, t0 = 0, first_v = -1;
  int exp_d [NN];
  layer_mac_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .act_vec(act_vec), .busy(busy), .done(done),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  always @(posedge clk) if (w_rd) begin
    if (int'(w_addr) < ROMSZ) w_data <= rom[w_addr];
    else chk("rom_addr_range", int'(w_addr), ROMSZ - 1);
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cnt - t0);
    end
  endtask
  always @(negedge clk) begin
    logic [10:0] e;
    #1;
    if (!reset && out_valid && first_v < 0) first_v = cnt - t0;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_idx", int'(out_idx), int'(e[10:8]));
        chk("out_data", int'(out_data), int'(e[7:0]));
      end
    end
  end
  task automatic load(input int wt [NN], input int bias [NN]);
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) rom[n*(NI+1)+k] = 8'(wt[n]);
      rom[n*(NI+1)+NI] = 8'(bias[n]);
    end
  endtask
  task automatic set_acts(input int a);
    for (int i = 0; i < NI; i++) act_vec[8*i +: 8] = 8'(a);
  endtask
  task automatic begin_run();
    for (int n = 0; n < NN; n++) exp_q.push_back({3'(n), 8'(exp_d[n])});
    @(negedge clk);
    start = 1;
    @(negedge clk);
    t0 = cnt;
    first_v = -1;
    start = 0;
  endtask
  task automatic finish_run(input int exp_done);
    int i;
    for (i = 0; i < 400 && !done; i++) @(negedge clk);
    chk("done_cycle", done ? cnt - t0 : -1, exp_done);
    chk("busy_at_done", int'(busy), 0);
    chk("first_valid_cycle", first_v, NI + 3);
    chk("queue_empty", exp_q.size(), 0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_in_done_ignored", int'(busy), 0);
  endtask
  task automatic skip_to(input int c);
    for (int i = 0; i < 400 && cnt - t0 < c; i++) @(negedge clk);
  endtask
  int wt2 [NN] = '{2, -1, 3, 0, -1, 4, 1, 2};
  int bi2 [NN] = '{-1, 0, 10, 127, 100, 0, 0, 7};
  int ex2 [NN] = '{59, 0, 100, 127, 70, 120, 30, 67};
  initial begin
    int vcount;
    logic [10:0] held;
    // reset held with start asserted
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", int'({busy, done, w_rd, out_valid, w_addr, out_idx, out_data}), 0);
    end
    reset = 0;
    start = 0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", int'({busy, w_rd, out_valid}), 0);
    end
    // scenario 2 with stray start pulses mid-run
    set_acts(1);
    load(wt2, bi2);
    exp_d = ex2;
    begin_run();
    skip_to(10);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_mid_run", int'(busy), 1);
    skip_to(40);
    start = 1;
    @(negedge clk);
    start = 0;
    finish_run(265);
    // wrap vs saturation
    set_acts(4);
    load('{4, 4, 4, 4, 4, 4, 4, 4}, '{0, 0, 0, 0, 0, 0, 0, 0});
`ifdef SCHED_SAT_EN
    exp_d = '{127, 127, 127, 127, 127, 127, 127, 127};
`else
    exp_d = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    begin_run();
    finish_run(265);
    // product truncation: 16*16 -> 0
    set_acts(0);
    act_vec[7:0] = 8'd16;
    load('{7, 7, 7, 7, 7, 7, 7, 7}, '{5, 5, 5, 5, 5, 5, 5, 5});
    for (int n = 0; n < NN; n++) rom[n*(NI+1)] = 8'd16;
    exp_d = '{5, 5, 5, 5, 5, 5, 5, 5};
    begin_run();
    finish_run(265);
    // output stall of 5 cycles at node 0
    set_acts(1);
    load(wt2, bi2);
    exp_d = ex2;
    out_ready = 0;
    begin_run();
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("stall_valid_seen", int'(out_valid), 1);
    held = {out_idx, out_data};
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", int'({out_valid, w_rd, out_idx, out_data}), int'({2'b10, held}));
      @(negedge clk);
    end
    out_ready = 1;
    finish_run(270);
    // reset during node 3 RUN
    begin_run();
    skip_to(108);
    chk("node3_running", int'(busy), 1);
    reset = 1;
    @(negedge clk);
    chk("abort_outputs", int'({busy, w_rd, out_valid}), 0);
    reset = 0;
    exp_q.delete();
    vcount = 0;
    repeat (60) begin
      @(negedge clk);
      vcount += int'(out_valid | done | busy);
    end
    chk("quiet_after_abort", vcount, 0);
    begin_run();
    finish_run(265);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
